tt_um_count_checker: RTL and testbench
======================================

TT_UM_COUNT_CHECKER -- requirements
Module: tt_um_count_checker

Interface
REQ-001 SHALL provide parameter LOCK_CNT, default 4, meaning consecutive correct increments required to enter LOCKED (legal 1..7).
REQ-002 SHALL provide parameter UNLOCK_ERR, default 2, meaning consecutive mismatches in LOCKED that return to SEARCH (legal 1..7).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-005 SHALL have port ena, input, 1, meaning design enable; low freezes all state.
REQ-006 SHALL have port ui_in, input, 8, meaning the incoming 8-bit free-running counter stream, one value per clock.
REQ-007 SHALL have port uo_out, output, 8, meaning the error count err_cnt.
REQ-008 SHALL have port uio_in, input, 8, meaning: [0] clr (synchronous error-count clear), [1] hold (suspend checking); [7:2] ignored.
REQ-009 SHALL have port uio_out, output, 8, meaning: [1:0]=0, [2] locked, [3] err_pulse, [4] searching, [7:5] run (consecutive-match count, saturating at 7).
REQ-010 SHALL have port uio_oe, output, 8, meaning the constant 8'b1111_1100.

Function
REQ-011 SHALL register ui_in into cur on each enabled edge, moving the old cur into prev.
REQ-012 SHALL keep a 2-bit prime count; comparison is valid only once two samples exist since reset.
REQ-013 SHALL define match as cur == prev + 1 modulo 256, so 255 followed by 0 is a match.
REQ-014 SHALL update state, run, err_cnt and err_pulse on the edge after the compared sample is registered, two edges after the value appears on ui_in.
REQ-015 SHALL implement FSM states SEARCH (reset) and LOCKED.
REQ-016 SEARCH: a match increments run and a mismatch zeroes it; go to LOCKED on the edge where the match count reaches LOCK_CNT.
REQ-017 LOCKED: a match zeroes miss_cnt and increments run; a mismatch increments miss_cnt, zeroes run, pulses err_pulse and increments err_cnt.
REQ-018 LOCKED: go to SEARCH, with run=0 and miss_cnt=0, on the edge where miss_cnt reaches UNLOCK_ERR.
REQ-019 SHALL not count mismatches in SEARCH, and err_pulse SHALL stay 0 there.
REQ-020 err_cnt SHALL be 8 bits, saturating at 255 with no wrap.
REQ-021 err_pulse SHALL be high for exactly one cycle per counted mismatch and SHALL be registered.
REQ-022 clr=1 SHALL zero err_cnt on that edge; clr takes priority over a simultaneous mismatch (err_cnt=0, err_pulse still asserts).
REQ-023 hold=1 SHALL continue sampling, suspend comparison (state, run, miss_cnt and err_cnt unchanged, err_pulse 0), and clear prime so the first post-hold pair is not compared.
REQ-024 ena=0 SHALL freeze all registers, including cur, prev and prime; err_pulse SHALL drop to 0.
REQ-025 locked and searching SHALL be mutually exclusive and exactly one of them SHALL be high at all times out of reset.

Reset
REQ-026 rst_n low SHALL immediately and asynchronously set cur=prev=0, prime=0, state=SEARCH, run=0, miss_cnt=0, err_cnt=0 and err_pulse=0, giving uo_out=0x00 and uio_out=0x10.
REQ-027 Reset asserted mid-operation SHALL take effect without waiting for clk, and the first two post-reset samples SHALL only prime the comparator.

Verification
REQ-028 Lock: reset, feed 0,1,2,...; SHALL see locked=1 two edges after value 4 is presented, with searching=0 and err_cnt=0.
REQ-029 Wrap and single glitch: locked, feed 253,254,255,0,1 -> no err_pulse; then feed 10,11,12,12,13 -> one err_pulse, err_cnt=1, stays locked, run restarts at 0.
REQ-030 Unlock: locked, feed 10,11,50,50 -> err_cnt +2, two err_pulses, then searching=1; resuming 51,52,53,54,55 -> relock.
REQ-031 Saturation and clear: run 260 relock-plus-single-glitch cycles -> err_cnt holds 255; assert clr on the same edge as a counted mismatch -> err_cnt=0 with err_pulse=1.
REQ-032 Hold and ena: hold=1 while feeding garbage -> no state change and err_cnt frozen; ena=0 for 5 cycles -> all outputs constant; ena back to 1 -> checking resumes after re-priming.
REQ-033 Async reset: assert rst_n low between clock edges while locked with err_cnt=7 -> uo_out=0 and uio_out=0x10 before the next edge.

Source files
------------

// File: rtl/tt_um_count_checker.sv
// Checks that ui_in carries a free-running +1 counter; locks after LOCK_CNT good steps, counts errors while locked.
// Latency: outputs reflect a sample two edges after it appears on ui_in; no backpressure, ena=0 freezes everything.
module tt_um_count_checker #(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_ERR = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  localparam logic [2:0] LOCK_C   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_C = 3'(UNLOCK_ERR);

  logic [7:0] cur, prev, err_cnt;
  logic [1:0] prime;
  logic [0:0] state;
  logic [2:0] run, miss_cnt;
  logic       err_pulse;

  logic [0:0] state_nxt;
  logic [2:0] run_nxt, miss_nxt;
  logic [7:0] err_nxt;
  logic       pulse_nxt;

  logic       clr, hold, cmp_vld, match;
  logic [7:0] prev_inc;
  logic [2:0] run_inc, miss_inc;
  logic       unused_uio;

  assign clr        = uio_in[0];
  assign hold       = uio_in[1];
  assign unused_uio = &{1'b0, uio_in[7:2]};

  // Comparison needs two samples since reset or since hold was released.
  assign cmp_vld  = (prime == 2'd2) && !hold;
  assign prev_inc = prev + 8'd1;
  assign match    = (cur == prev_inc);
  assign run_inc  = (run == 3'd7) ? 3'd7 : run + 3'd1;
  assign miss_inc = miss_cnt + 3'd1;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    miss_nxt  = miss_cnt;
    err_nxt   = err_cnt;
    pulse_nxt = 1'b0;
    if (cmp_vld) begin
      if (state == S_SEARCH) begin
        if (match) begin
          run_nxt = run_inc;
          if (run_inc == LOCK_C) state_nxt = S_LOCKED;
        end else begin
          run_nxt = 3'd0;
        end
      end else begin
        if (match) begin
          miss_nxt = 3'd0;
          run_nxt  = run_inc;
        end else begin
          pulse_nxt = 1'b1;
          run_nxt   = 3'd0;
          if (err_cnt != 8'hff) err_nxt = err_cnt + 8'd1;
          if (miss_inc == UNLOCK_C) begin
            state_nxt = S_SEARCH;
            miss_nxt  = 3'd0;
          end else begin
            miss_nxt = miss_inc;
          end
        end
      end
    end
    // Clear wins over a simultaneous counted mismatch; the pulse still fires.
    if (clr) err_nxt = 8'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur       <= 8'd0;
      prev      <= 8'd0;
      prime     <= 2'd0;
      state     <= S_SEARCH;
      run       <= 3'd0;
      miss_cnt  <= 3'd0;
      err_cnt   <= 8'd0;
      err_pulse <= 1'b0;
    end else if (ena) begin
      prev      <= cur;
      cur       <= ui_in;
      prime     <= hold ? 2'd0 : ((prime == 2'd2) ? 2'd2 : prime + 2'd1);
      state     <= state_nxt;
      run       <= run_nxt;
      miss_cnt  <= miss_nxt;
      err_cnt   <= err_nxt;
      err_pulse <= pulse_nxt;
    end else begin
      err_pulse <= 1'b0;
    end
  end

  assign uo_out  = err_cnt;
  assign uio_out = {run, (state == S_SEARCH), err_pulse, (state == S_LOCKED), 2'b00};
  assign uio_oe  = 8'b1111_1100;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Random and directed counter streams checked against a sample-level reference model.
module tb_tt_um_count_checker;

  localparam int LOCK_CNT   = 4;
  localparam int UNLOCK_ERR = 2;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  // reference model state
  int m_cur, m_prev, m_prime, m_run, m_miss, m_err;
  bit m_locked, m_pulse;
  int last_v;

  tt_um_count_checker #(.LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = 0; m_prev = 0; m_prime = 0; m_run = 0; m_miss = 0; m_err = 0;
    m_locked = 0; m_pulse = 0;
  endtask

  // One rising edge of the checker, expressed directly from the stream rules.
  task automatic model_step(input int v, input bit clr, input bit hold, input bit en);
    bit cmp, match;
    if (!en) begin
      m_pulse = 0;
      return;
    end
    cmp   = (m_prime == 2) && !hold;
    match = (m_cur == ((m_prev + 1) % 256));
    m_pulse = 0;
    if (cmp) begin
      if (!m_locked) begin
        if (match) begin
          m_run = (m_run + 1 > 7) ? 7 : m_run + 1;
          if (m_run == LOCK_CNT) m_locked = 1;
        end else begin
          m_run = 0;
        end
      end else if (match) begin
        m_miss = 0;
        m_run = (m_run + 1 > 7) ? 7 : m_run + 1;
      end else begin
        m_pulse = 1;
        m_err = (m_err + 1 > 255) ? 255 : m_err + 1;
        m_run = 0;
        m_miss++;
        if (m_miss == UNLOCK_ERR) begin
          m_locked = 0;
          m_miss = 0;
        end
      end
    end
    if (clr) m_err = 0;
    m_prev = m_cur;
    m_cur = v;
    m_prime = hold ? 0 : ((m_prime + 1 > 2) ? 2 : m_prime + 1);
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_uio;
    logic [2:0] r;
    r = 3'(m_run);
    exp_uio = {r, ~m_locked, m_pulse, m_locked, 2'b00};
    check_eq({tag, ".err_cnt"}, 32'(uo_out), 32'(m_err));
    check_eq({tag, ".uio_out"}, 32'(uio_out), 32'(exp_uio));
    check_eq({tag, ".uio_oe"}, 32'(uio_oe), 32'hfc);
    check_eq({tag, ".excl"}, 32'(uio_out[2] ^ uio_out[4]), 32'd1);
  endtask

  // Drive one sample during the low phase, then check after the edge.
  task automatic cycle(input string tag, input int v, input bit clr, input bit hold, input bit en);
    ui_in  = 8'(v);
    uio_in = {6'b0, hold, clr};
    ena    = en;
    model_step(v, clr, hold, en);
    if (en) last_v = v;
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic feed(input string tag, input int v);
    cycle(tag, v, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int v;
    rst_n = 1'b0;
    last_v = 0;
    do_reset();

    // lock: 0,1,2,... locked two edges after value 4
    for (int i = 0; i < 6; i++) feed("lock", i);
    check_eq("lock.locked", 32'(uio_out[2]), 32'd1);
    check_eq("lock.search", 32'(uio_out[4]), 32'd0);
    check_eq("lock.err", 32'(uo_out), 32'd0);

    // run the counter up to the wrap point
    for (int i = 6; i < 253; i++) feed("ramp", i);
    feed("wrap", 253); feed("wrap", 254); feed("wrap", 255); feed("wrap", 0); feed("wrap", 1);
    feed("wrap", 2);
    check_eq("wrap.err", 32'(uo_out), 32'd0);
    for (int i = 3; i < 10; i++) feed("pre", i);
    feed("glitch", 10); feed("glitch", 11); feed("glitch", 12); feed("glitch", 12);
    feed("glitch", 13);
    check_eq("glitch.pulse", 32'(uio_out[3]), 32'd1);
    feed("glitch", 14);
    check_eq("glitch.err", 32'(uo_out), 32'd1);
    check_eq("glitch.locked", 32'(uio_out[2]), 32'd1);

    // unlock: two back-to-back mismatches, then relock
    feed("unlock", 15); feed("unlock", 50); feed("unlock", 50);
    for (int i = 51; i < 58; i++) feed("relock", i);
    check_eq("unlock.err", 32'(uo_out), 32'd3);
    check_eq("relock.locked", 32'(uio_out[2]), 32'd1);

    // saturation: repeated duplicates give one counted mismatch per pair
    v = last_v;
    for (int i = 0; i < 300; i++) begin
      feed("sat", v);
      v = (v + 1) % 256;
      feed("sat", v);
    end
    feed("sat", v);
    check_eq("sat.err", 32'(uo_out), 32'd255);
    v = (v + 1) % 256;
    cycle("clr", v, 1'b1, 1'b0, 1'b1);
    check_eq("clr.err", 32'(uo_out), 32'd0);
    check_eq("clr.pulse", 32'(uio_out[3]), 32'd1);

    // hold with garbage, then ena low, then resume
    for (int i = 0; i < 6; i++) cycle("hold", int'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle("ena", int'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    v = int'($urandom_range(0, 255));
    for (int i = 0; i < 8; i++) begin
      feed("resume", v);
      v = (v + 1) % 256;
    end

    // random stream with glitches, holds, clears and enable gaps
    v = last_v;
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit c, h, e;
      r = int'($urandom_range(0, 99));
      v = (r < 8) ? int'($urandom_range(0, 255)) : (last_v + 1) % 256;
      c = ($urandom_range(0, 99) < 3);
      h = ($urandom_range(0, 99) < 5);
      e = ($urandom_range(0, 99) >= 5);
      cycle("rand", v, c, h, e);
    end

    // async reset while locked with seven errors
    do_reset();
    for (int i = 0; i < 10; i++) feed("pre7", i);
    v = 9;
    for (int i = 0; i < 7; i++) begin
      feed("e7", v);
      v++;
      feed("e7", v);
    end
    feed("e7", v);
    check_eq("e7.err", 32'(uo_out), 32'd7);
    check_eq("e7.locked", 32'(uio_out[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst.uo_out", 32'(uo_out), 32'd0);
    check_eq("arst.uio_out", 32'(uio_out), 32'h10);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    feed("post", 20); feed("post", 21);
    feed("post", 40);
    check_eq("post.search", 32'(uio_out[4]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
